usbd_report_encoder: RTL and testbench

Transmit-side counterpart of the USB host HID report decoder. Takes the NES 8-bit button state and builds an 8-byte darfon/dragonrise-format gamepad report. It streams that report byte-serially to a USB device-side IN endpoint, either on button change or on a periodic idle refresh. A report produced here and fed back into the host decoder reproduces the original button state.

---
 rtl/usbd_report_encoder_if.sv | 9 +
 rtl/usbd_report_encoder.sv | 111 +++++++++++
 tb/tb_usbd_report_encoder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/usbd_report_encoder_if.sv
// usbd_report_encoder_if: byte stream from the report encoder into a USB IN endpoint.
interface usbd_report_encoder_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       last;
    modport master (output data, valid, last, input ready);
    modport slave  (input data, valid, last, output ready);
endinterface

// File: rtl/usbd_report_encoder.sv
// usbd_report_encoder: NES button state to 8-byte dragonrise gamepad report, streamed byte-serially.
module usbd_report_encoder #(
    parameter int c_clk_hz  = 6000000,
    parameter int c_idle_hz = 4,
    parameter int c_use_hat = 0
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [7:0]                   i_btn,
    usbd_report_encoder_if.master        ep,
    output logic [63:0]                  o_report,
    output logic                         o_report_valid,
    output logic                         o_busy
);
    localparam int c_div_raw = c_clk_hz / (c_idle_hz > 0 ? c_idle_hz : 1);
    localparam int c_div     = c_div_raw > 1 ? c_div_raw : 2;
    localparam int c_tw      = $clog2(c_div);
    localparam logic [c_tw-1:0] c_tload = c_tw'(c_div - 1);

    typedef enum logic {IDLE, SEND} state_t;
    state_t            state_q, state_d;
    logic [7:0]        in_q, sent_q, sent_d, lat_q, lat_d;
    logic [63:0]       buf_q, buf_d, report_d, enc;
    logic [2:0]        idx_q, idx_d;
    logic [c_tw-1:0]   tmr_q, tmr_d;
    logic              pend_q, pend_d, arm_q, exp_q, exp_d, rv_d;
    logic              l, r, u, d, trig, acc, done;
    logic [3:0]        hat;
    logic [7:0]        x, y;

    // Opposing directions cancel per axis before anything is encoded.
    assign l   = in_q[6] & ~in_q[7];
    assign r   = in_q[7] & ~in_q[6];
    assign u   = in_q[4] & ~in_q[5];
    assign d   = in_q[5] & ~in_q[4];
    assign hat = (c_use_hat == 0) ? 4'hF :
                 u ? (r ? 4'd1 : l ? 4'd7 : 4'd0) :
                 d ? (r ? 4'd3 : l ? 4'd5 : 4'd4) :
                 r ? 4'd2 : l ? 4'd6 : 4'hF;
    assign x   = (c_use_hat != 0) ? 8'h7F : l ? 8'h00 : r ? 8'hFF : 8'h7F;
    assign y   = (c_use_hat != 0) ? 8'h7F : u ? 8'h00 : d ? 8'hFF : 8'h7F;
    assign enc = {8'h00, 2'b00, in_q[3], in_q[2], 4'h0, 1'b0, in_q[0], in_q[1], 1'b0, hat,
                  8'h7F, 8'h7F, 8'h7F, y, x};

    assign ep.valid = state_q == SEND;
    assign o_busy   = state_q == SEND;
    assign ep.last  = (state_q == SEND) && (idx_q == 3'd7);
    assign ep.data  = (state_q == SEND) ? buf_q[{idx_q, 3'b000} +: 8] : 8'h00;
    assign acc      = ep.valid & ep.ready;
    assign done     = acc & (idx_q == 3'd7);
    // Expiry is registered so the refresh path has the same one-cycle latency as the change path.
    assign trig     = arm_q & (pend_q | (in_q != sent_q) | ((c_idle_hz != 0) & exp_q));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        buf_d    = buf_q;
        lat_d    = lat_q;
        sent_d   = sent_q;
        report_d = o_report;
        pend_d   = pend_q;
        rv_d     = 1'b0;
        tmr_d    = (state_q == IDLE && tmr_q != '0) ? tmr_q - 1'b1 : tmr_q;
        exp_d    = (state_q == IDLE) && (tmr_q == '0);
        if (state_q == IDLE && trig) begin
            state_d = SEND;
            idx_d   = 3'd0;
            buf_d   = enc;
            lat_d   = in_q;
        end
        if (acc) idx_d = idx_q + 3'd1;
        if (done) begin
            state_d  = IDLE;
            sent_d   = lat_q;
            report_d = buf_q;
            rv_d     = 1'b1;
            tmr_d    = c_tload;
            pend_d   = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= IDLE;
            in_q           <= '0;
            sent_q         <= '0;
            lat_q          <= '0;
            buf_q          <= '0;
            idx_q          <= '0;
            tmr_q          <= c_tload;
            pend_q         <= 1'b1;
            arm_q          <= 1'b0;
            exp_q          <= 1'b0;
            o_report       <= '0;
            o_report_valid <= 1'b0;
        end else begin
            state_q        <= state_d;
            in_q           <= i_btn;
            sent_q         <= sent_d;
            lat_q          <= lat_d;
            buf_q          <= buf_d;
            idx_q          <= idx_d;
            tmr_q          <= tmr_d;
            pend_q         <= pend_d;
            arm_q          <= 1'b1;
            exp_q          <= exp_d;
            o_report       <= report_d;
            o_report_valid <= rv_d;
        end
    end
endmodule

// File: tb/tb_usbd_report_encoder.sv
// tb_usbd_report_encoder: two encoders (stick mode with refresh, hat mode change-only) against a behavioural model.
module tb_usbd_report_encoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] btn = 8'h00;
    logic       rdy = 1'b1;
    int         cyc = 0;
    int         n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    usbd_report_encoder_if e0 ();
    usbd_report_encoder_if e1 ();
    assign e0.ready = rdy;
    assign e1.ready = rdy;

    logic [1:0][63:0] rep;
    logic [1:0]       rv, busy, dv, dl;
    logic [1:0][7:0]  dd;
    assign dv[0] = e0.valid;
    assign dv[1] = e1.valid;
    assign dl[0] = e0.last;
    assign dl[1] = e1.last;
    assign dd[0] = e0.data;
    assign dd[1] = e1.data;

    usbd_report_encoder #(.c_clk_hz(1000), .c_idle_hz(10), .c_use_hat(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn), .ep(e0.master),
        .o_report(rep[0]), .o_report_valid(rv[0]), .o_busy(busy[0]));
    usbd_report_encoder #(.c_clk_hz(1000), .c_idle_hz(0), .c_use_hat(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn), .ep(e1.master),
        .o_report(rep[1]), .o_report_valid(rv[1]), .o_busy(busy[1]));

    task automatic chk(input int i, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL dut%0d %s: got %h expected %h (cycle %0d)", i, nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model_rep(input logic [7:0] b, input bit hat);
        logic [3:0]  ht [9];
        logic [7:0]  by [8];
        logic [63:0] r;
        int dx, dy;
        ht = '{4'h7, 4'h0, 4'h1, 4'h6, 4'hF, 4'h2, 4'h5, 4'h4, 4'h3};
        dx = int'(b[7]) - int'(b[6]);
        dy = int'(b[5]) - int'(b[4]);
        for (int k = 0; k < 8; k++) by[k] = 8'h7F;
        if (!hat) begin
            by[0] = dx < 0 ? 8'h00 : dx > 0 ? 8'hFF : 8'h7F;
            by[1] = dy < 0 ? 8'h00 : dy > 0 ? 8'hFF : 8'h7F;
        end
        by[5] = {1'b0, b[0], b[1], 1'b0, hat ? ht[(dy + 1) * 3 + dx + 1] : 4'hF};
        by[6] = {2'b00, b[3], b[2], 4'h0};
        by[7] = 8'h00;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = by[k];
        return r;
    endfunction

    // Host-side view of a report, as the HID decoder would read it back.
    function automatic logic [7:0] decode(input logic [63:0] r, input bit hat);
        logic [7:0] x, y, b5, b6;
        logic [3:0] h;
        logic up, dn, lf, rt;
        x = r[7:0]; y = r[15:8]; b5 = r[47:40]; b6 = r[55:48]; h = b5[3:0];
        if (hat) begin
            up = (h == 4'd0) || (h == 4'd1) || (h == 4'd7);
            rt = (h >= 4'd1) && (h <= 4'd3);
            dn = (h >= 4'd3) && (h <= 4'd5);
            lf = (h >= 4'd5) && (h <= 4'd7);
        end else begin
            lf = x < 8'h40; rt = x > 8'hC0; up = y < 8'h40; dn = y > 8'hC0;
        end
        return {rt, lf, dn, up, b6[5], b6[4], b5[5], b5[6]};
    endfunction

    function automatic logic [7:0] clr(input logic [7:0] b);
        logic [7:0] o;
        o = b;
        if (b[7] & b[6]) o[7:6] = 2'b00;
        if (b[5] & b[4]) o[5:4] = 2'b00;
        return o;
    endfunction

    bit          m_busy [2], m_pend [2], m_arm [2], m_rv [2];
    int          m_idx [2], m_idle [2];
    logic [63:0] m_buf [2], m_rep [2];
    logic [7:0]  m_in [2], m_sent [2], m_lat [2];
    int          per [2] = '{100, 0};

    // Advance the model over the edge just passed, then compare every output.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_busy[i] = 0; m_pend[i] = 1; m_arm[i] = 0; m_rv[i] = 0; m_idx[i] = 0;
                m_idle[i] = 0; m_rep[i] = '0; m_in[i] = '0; m_sent[i] = '0;
            end else begin
                m_rv[i] = 0;
                if (m_busy[i]) begin
                    if (rdy) begin
                        if (m_idx[i] == 7) begin
                            m_busy[i] = 0; m_sent[i] = m_lat[i]; m_rep[i] = m_buf[i];
                            m_rv[i] = 1; m_pend[i] = 0; m_idle[i] = 0;
                        end else m_idx[i]++;
                    end
                end else if (m_arm[i] && (m_pend[i] || m_in[i] != m_sent[i] ||
                                          (per[i] > 0 && m_idle[i] >= per[i]))) begin
                    m_busy[i] = 1; m_idx[i] = 0; m_lat[i] = m_in[i];
                    m_buf[i] = model_rep(m_in[i], i == 1);
                end else m_idle[i]++;
                m_arm[i] = 1;
                m_in[i] = btn;
            end
            chk(i, "valid", dv[i], m_busy[i]);
            chk(i, "busy", busy[i], m_busy[i]);
            chk(i, "last", dl[i], m_busy[i] && m_idx[i] == 7);
            if (m_busy[i]) chk(i, "data", dd[i], m_buf[i][8*m_idx[i] +: 8]);
            chk(i, "report", rep[i], m_rep[i]);
            chk(i, "rvalid", rv[i], m_rv[i]);
            if (m_rv[i]) chk(i, "loopback", decode(rep[i], i == 1), clr(m_sent[i]));
        end
    end

    task automatic wait_start(output int t);
        bit p;
        p = dv[0];
        t = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (dv[0] && !p) begin
                t = cyc;
                break;
            end
            p = dv[0];
        end
        if (t < 0) chk(0, "start_timeout", 0, 1);
    endtask

    task automatic wait_rv(input int i);
        bit ok;
        ok = 0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            ok = rv[i];
        end
        if (!ok) chk(i, "rv_timeout", 0, 1);
    endtask

    initial begin
        int c, t, s1, s2, s3, gap;
        chk(0, "pin_idle", model_rep(8'h00, 0), 64'h00000F7F7F7F7F7F);
        chk(0, "pin_right_a", model_rep(8'h81, 0), 64'h00004F7F7F7F7FFF);
        chk(1, "pin_hat_ul", model_rep(8'h5C, 1), 64'h0030077F7F7F7F7F);
        chk(1, "pin_hat_lr", model_rep(8'hC0, 1), 64'h00000F7F7F7F7F7F);
        repeat (3) @(negedge clk);
        chk(0, "rst_data", dd[0], 8'h00);
        chk(0, "rst_report", rep[0], 64'h0);
        #1 rst_n = 1'b1;
        c = cyc;
        wait_start(t);
        chk(0, "first_latency", t - c, 2);
        wait_rv(0);
        chk(0, "first_report", rep[0], 64'h00000F7F7F7F7F7F);
        repeat (3) @(negedge clk);
        #1 btn = 8'h81;
        c = cyc;
        wait_start(t);
        chk(0, "chg_latency", t - c, 2);
        wait_rv(0);
        chk(0, "right_a", rep[0], 64'h00004F7F7F7F7FFF);
        chk(1, "right_a_hat", rep[1], 64'h0000427F7F7F7F7F);
        #1 btn = 8'h5C;
        wait_rv(1);
        chk(1, "hat_ul", rep[1], 64'h0030077F7F7F7F7F);
        #1 btn = 8'hC0;
        wait_rv(1);
        chk(1, "hat_lr", rep[1], 64'h00000F7F7F7F7F7F);
        chk(0, "stick_lr", rep[0], 64'h00000F7F7F7F7F7F);
        repeat (2) @(negedge clk);
        #1 btn = 8'h01;
        wait_start(t);
        repeat (3) @(negedge clk);
        #1 rdy = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk(0, "stall_hold", dd[0], 8'h7F);
            if (k == 2) #1 btn = 8'h02;
        end
        #1 rdy = 1'b1;
        wait_rv(0);
        chk(0, "stall_b5", rep[0][47:40], 8'h4F);
        gap = 0;
        while (!dv[0] && gap < 20) begin
            gap++;
            @(negedge clk);
        end
        chk(0, "idle_gap", gap, 1);
        wait_rv(0);
        chk(0, "second_b5", rep[0][47:40], 8'h2F);
        wait_start(s1);
        wait_start(s2);
        wait_start(s3);
        chk(0, "period1", s2 - s1, 109);
        chk(0, "period2", s3 - s2, 109);
        repeat (40) @(negedge clk);
        #1 btn = 8'h03;
        c = cyc;
        wait_start(s1);
        chk(0, "mid_change", s1 - c, 2);
        wait_start(s2);
        chk(0, "period_restart", s2 - s1, 109);
        for (int b = 0; b < 256; b++) begin
            #1 btn = 8'(b);
            wait_rv(0);
        end
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 19) == 0) btn = 8'($urandom);
            rdy = $urandom_range(0, 3) != 0;
            rst_n = $urandom_range(0, 399) != 0;
        end
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
